multiplication: RTL and testbench

MULTIPLICATION -- requirements
Module: multiplication

---
 rtl/linalg_pkg.sv | 22 ++
 rtl/multiplication_if.sv | 22 ++
 rtl/mult_step.sv | 25 ++
 rtl/multiplication.sv | 90 +++++++++
 tb/tb_multiplication.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/linalg_pkg.sv
`default_nettype none
// ============================================================================
// linalg_pkg: shared FSM state encoding and sizing helpers for arithmetic blocks
// Rev 1.0
// ============================================================================
package linalg_pkg;

    localparam int c_default_width = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplication_if.sv
`default_nettype none
// ============================================================================
// multiplication_if: start/operand request and ready/valid/result response
// Rev 1.0
// ============================================================================
interface multiplication_if
    import linalg_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 ready;
    logic                 valid;
    logic [2*WIDTH-1:0]   Res;
    logic                 ovf;

    modport master (output start, A, B, input ready, valid, Res, ovf);
    modport slave  (input start, A, B, output ready, valid, Res, ovf);
endinterface
`default_nettype wire

// File: rtl/mult_step.sv
`default_nettype none
// ============================================================================
// mult_step: one shift-and-add iteration (conditional add, then shift operands)
// Rev 1.0
// ============================================================================
module mult_step
    import linalg_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic [2*WIDTH-1:0] i_acc,
    input  wire logic [2*WIDTH-1:0] i_mcand,
    input  wire logic [WIDTH-1:0]   i_mplier,
    output logic      [2*WIDTH-1:0] o_acc,
    output logic      [2*WIDTH-1:0] o_mcand,
    output logic      [WIDTH-1:0]   o_mplier
);

    // The sum never exceeds 2*WIDTH bits, so the dropped carry is always zero.
    assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand  = i_mcand << 1;
    assign o_mplier = i_mplier >> 1;

endmodule
`default_nettype wire

// File: rtl/multiplication.sv
`default_nettype none
// ============================================================================
// multiplication: fixed-latency sequential unsigned multiplier (WIDTH steps)
// Rev 1.0
// ============================================================================
module multiplication
    import linalg_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input wire logic        clk,
    input wire logic        rst,
    multiplication_if.slave mul
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_res;
    logic                 r_ovf;

    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_mcand_nxt;
    logic [WIDTH-1:0]     w_mplier_nxt;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt)
    );

    assign mul.ready = (r_state == IDLE);
    assign mul.valid = (r_state == DONE);
    assign mul.Res   = r_res;
    assign mul.ovf   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mul.start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, mul.A};
                        r_mplier <= mul.B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    // Result is captured from the final step's sum on the same edge.
                    if (r_cnt == c_last) begin
                        r_res   <= w_acc_nxt;
                        r_ovf   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplication.sv
`default_nettype none
// ============================================================================
// tb_multiplication: directed vector table plus reset/back-to-back sequences
// Rev 1.0
// ============================================================================
module tb_multiplication;

    localparam int c_w = 32;

    typedef struct {
        logic [c_w-1:0]   a;
        logic [c_w-1:0]   b;
        logic [2*c_w-1:0] res;
        logic             ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multiplication_if #(.WIDTH(c_w)) mif ();

    multiplication #(
        .WIDTH (c_w)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mul (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle WIDTH+2.
    task automatic run_op(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                          input logic [2*c_w-1:0] prev_res, input bit disturb,
                          input logic [2*c_w-1:0] exp_res, input logic exp_ovf,
                          input string name);
        int vcyc, vcnt, rdy_err, res_chg;
        check({name, " ready_at_accept"}, 64'(mif.ready), 64'd1);
        mif.start = 1'b1;
        mif.A     = a;
        mif.B     = b;
        vcyc = -1; vcnt = 0; rdy_err = 0; res_chg = 0;
        for (int c = 1; c <= c_w + 2; c++) begin
            @(posedge clk);
            #1;
            if (disturb && c >= 3 && c <= 20) begin
                mif.start = 1'b1;
                mif.A     = 32'd9;
                mif.B     = 32'd9;
            end else begin
                mif.start = 1'b0;
                mif.A     = $urandom;
                mif.B     = $urandom;
            end
            @(negedge clk);
            if (mif.valid === 1'b1) begin
                vcnt++;
                vcyc = c;
            end
            if (mif.ready !== (c == c_w + 2)) rdy_err++;
            if (vcnt == 0 && mif.Res !== prev_res) res_chg++;
            if (c == c_w + 1) begin
                check({name, " Res"}, mif.Res, exp_res);
                check({name, " ovf"}, 64'(mif.ovf), 64'(exp_ovf));
            end
        end
        check({name, " valid_cycle"}, 64'(vcyc), 64'(c_w + 1));
        check({name, " valid_count"}, 64'(vcnt), 64'd1);
        check({name, " ready_profile_errs"}, 64'(rdy_err), 64'd0);
        check({name, " res_hold_errs"}, 64'(res_chg), 64'd0);
    endtask

    task automatic check_idle_reset(input string name);
        check({name, " ready"}, 64'(mif.ready), 64'd1);
        check({name, " valid"}, 64'(mif.valid), 64'd0);
        check({name, " Res"}, mif.Res, 64'd0);
        check({name, " ovf"}, 64'(mif.ovf), 64'd0);
    endtask

    initial begin
        vec_t vecs[8];
        logic [2*c_w-1:0] last_res;
        int extra_valid;

        vecs[0] = '{32'd6,          32'd7,          64'd42,                  1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b1};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0,                   1'b0};
        vecs[3] = '{32'd1,          32'd1,          64'd1,                   1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 1'b0};
        vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 1'b1};
        vecs[6] = '{32'h1234_5678,  32'h10,         64'h0000_0001_2345_6780, 1'b1};
        vecs[7] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 1'b1};

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        mif.start = 1'b0;
        mif.A     = '0;
        mif.B     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");

        // Start accepted on the very first edge after reset release; ops run back-to-back.
        rst      = 1'b0;
        last_res = '0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, last_res, 1'b0, vecs[i].res, vecs[i].ovf,
                   $sformatf("vec%0d", i));
            last_res = vecs[i].res;
        end

        // Start and operand churn during BUSY must not disturb or queue.
        mif.start = 1'b0;
        @(negedge clk);
        run_op(32'd3, 32'd5, last_res, 1'b1, 64'd15, 1'b0, "busy_start");
        last_res    = 64'd15;
        extra_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mif.valid === 1'b1) extra_valid++;
        end
        check("busy_start no_second_valid", 64'(extra_valid), 64'd0);
        check("busy_start Res_held", mif.Res, 64'd15);

        // Reset in cycle 10 of an operation aborts it with no result.
        mif.start = 1'b1;
        mif.A     = 32'd5;
        mif.B     = 32'd7;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_reset("mid_reset");
        @(negedge clk);
        check_idle_reset("mid_reset_held");
        rst = 1'b0;
        run_op(32'd2, 32'h8000_0000, 64'd0, 1'b0, 64'h0000_0001_0000_0000, 1'b1, "after_reset");

        // Back-to-back: second start in the first ready cycle.
        run_op(32'd10, 32'd10, 64'h0000_0001_0000_0000, 1'b0, 64'd100, 1'b0, "back2back");
        mif.start = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
